dmem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory interface, sitting between the MEM stage and a multi-cycle data memory.
//  - Converts the single-cycle mem_read/mem_write strobes into a req/ack handshake.
//  - Stalls the pipeline while an access is outstanding.
//  - Returns load data with a valid pulse.
//  - Flags protocol errors: timeout, and misalignment when enabled.

---
 rtl/dmem_access_ctrl_pkg.sv | 23 ++
 rtl/dmem_access_ctrl_timeout_cnt.sv | 53 +++++
 rtl/dmem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared types and defaults for the data-memory access controller:
//   - default word width and ack timeout
//   - FSM state encoding (2 bits: IDLE/REQ/DONE/ERR)
//   - byte-offset width used to form word addresses
// ---------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

    localparam int unsigned WORD_W_DEF      = 64;
    localparam int unsigned TIMEOUT_CYC_DEF = 15;

    // Byte address -> word address shift (8-byte words).
    localparam int unsigned BYTE_OFF_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } dmc_state_e;

endpackage

// File: rtl/dmem_access_ctrl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// dmc_timeout_cnt
// Wait counter for an outstanding memory request. Cleared when a request is
// launched, counts once per enabled cycle, saturates instead of wrapping, and
// flags expiry on the last permitted wait cycle.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-high
//   clear   in  zero the count (takes priority over enable)
//   enable  in  count this cycle (request outstanding)
//   expire  out enable && count == TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module dmc_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Initiator side of the data-memory interface between the MEM stage and a
// multi-cycle data memory. Turns single-cycle mem_read/mem_write strobes into a
// dm_req/dm_ack handshake, stalls the pipeline while an access is outstanding,
// returns load data with a one-cycle valid pulse and raises a sticky error on
// timeout, stray ack, simultaneous read+write, or (optionally) misalignment.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject requests whose byte
// address is not 8-byte aligned (no dm_req, straight to the error state).
//
// Ports:
//   clk, reset           clock (rising) / synchronous active-high reset
//   mem_read, mem_write  request strobes from MEM stage (held while stalled)
//   mem_address          byte address
//   mem_write_data       store data
//   stall                freeze PC and pipeline registers
//   load_data/load_valid captured load result / 1-cycle update pulse
//   err                  sticky error flag
//   dm_req/dm_we         memory request / write-not-read
//   dm_addr/dm_wdata     word address (mem_address>>3) / store data
//   dm_ack/dm_rdata      memory completion / read data
// ---------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_write_data,
    output logic              stall,
    output logic [WORD_W-1:0] load_data,
    output logic              load_valid,
    output logic              err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [WORD_W-1:0] dm_addr,
    output logic [WORD_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [WORD_W-1:0] dm_rdata
);

    dmc_state_e        state_q,      state_d;
    logic [WORD_W-1:0] dm_addr_q,    dm_addr_d;
    logic [WORD_W-1:0] dm_wdata_q,   dm_wdata_d;
    logic              dm_we_q,      dm_we_d;
    logic [WORD_W-1:0] load_data_q,  load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              err_q,        err_d;
    // Read and write were both asserted: the write is issued and the error is
    // reported once it completes.
    logic              dual_q,       dual_d;

    logic req_in;
    logic misaligned;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_expire;

    assign req_in = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (mem_address[BYTE_OFF_W-1:0] != '0);
`else
    assign misaligned = 1'b0;
`endif

    // Counter is zeroed on the edge that enters REQ, so it reads 0 in the
    // first dm_req cycle and expires in cycle TIMEOUT_CYC.
    assign cnt_clear = (state_q == ST_IDLE) && req_in && !misaligned;
    assign cnt_en    = (state_q == ST_REQ);

    dmc_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expire (cnt_expire)
    );

    always_comb begin
        state_d      = state_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_we_d      = dm_we_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        err_d        = err_q;
        dual_d       = dual_q;
        stall        = 1'b0;
        dm_req       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        // Combinational stall: the pipeline freezes in the
                        // same cycle the request is seen.
                        stall      = 1'b1;
                        dm_addr_d  = mem_address >> BYTE_OFF_W;
                        dm_wdata_d = mem_write_data;
                        dm_we_d    = mem_write;
                        dual_d     = mem_read & mem_write;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                if (dm_ack) begin
                    if (!dm_we_q) begin
                        load_data_d  = dm_rdata;
                        load_valid_d = 1'b1;
                    end
                    if (dual_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (cnt_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end

            // One unstalled cycle lets the pipeline advance past the
            // instruction that is still on mem_read/mem_write, so it never
            // retriggers.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            // Terminal until reset; late acks and new requests are ignored.
            ST_ERR: begin
                err_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An ack with no outstanding request is a protocol violation.
        if (dm_ack && (state_q != ST_REQ)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            dm_we_q      <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            dual_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_we_q      <= dm_we_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            err_q        <= err_d;
            dual_q       <= dual_d;
        end
    end

    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign dm_we      = dm_we_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Scoreboard bench for dmem_access_ctrl. The stimulus thread pushes the
// expected memory request / load result before each access; a negedge monitor
// pops and compares whenever the DUT raises dm_req or load_valid. Cycle-level
// properties (stall length, burst count, error flag) are checked inline.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [W-1:0] mem_address = '0;
    logic [W-1:0] mem_write_data = '0;
    logic         dm_ack = 1'b0;
    logic [W-1:0] dm_rdata = '0;

    logic         stall;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         err;
    logic         dm_req;
    logic         dm_we;
    logic [W-1:0] dm_addr;
    logic [W-1:0] dm_wdata;

    dmem_access_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .stall          (stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .err            (err),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_ack         (dm_ack),
        .dm_rdata       (dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
    } req_t;

    req_t         req_q[$];
    logic [W-1:0] ld_q[$];
    req_t         cur;
    logic         prev_req = 1'b0;

    int n_cmp  = 0;
    int n_bad  = 0;
    int bursts = 0;
    int lv_cnt = 0;
    int sc, rc, b0, l0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_req(input logic [W-1:0] addr, input logic we, input logic [W-1:0] wdata);
        req_t r;
        r.addr  = addr;
        r.we    = we;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    // Monitor: compares every presented request and load result.
    always @(negedge clk) begin
        if (dm_req) begin
            if (!prev_req) begin
                bursts++;
                if (req_q.size() == 0) begin
                    check("unexpected_dm_req", 1, 0);
                end else begin
                    cur = req_q.pop_front();
                end
            end
            check("dm_addr", dm_addr, cur.addr);
            check("dm_we", W'(dm_we), W'(cur.we));
            if (cur.we) check("dm_wdata", dm_wdata, cur.wdata);
        end
        if (load_valid) begin
            lv_cnt++;
            if (ld_q.size() == 0) check("unexpected_load_valid", 1, 0);
            else check("load_data", load_data, ld_q.pop_front());
        end
        prev_req = dm_req;
    end

    // Issue one request and act as the memory: ack on the ack_at-th dm_req
    // cycle (0 = never). Inputs stay asserted through DONE/ERR like a real
    // MEM stage; returns at the negedge of the first cycle with dm_req low.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [W-1:0] addr, input logic [W-1:0] wdata,
                              input int ack_at, input logic [W-1:0] rdata,
                              output int stall_cyc, output int req_cyc);
        stall_cyc = 0;
        req_cyc   = 0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_write_data = wdata;
        @(negedge clk);
        if (stall) stall_cyc++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            dm_ack = 1'b0;
            if (!dm_req) begin
                @(negedge clk);
                if (stall) stall_cyc++;
                break;
            end
            req_cyc++;
            if (req_cyc == ack_at) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
            end
            @(negedge clk);
            if (stall) stall_cyc++;
        end
        dm_ack = 1'b0;
    endtask

    task automatic next_idle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", W'(stall), 0);
        check("rst_dm_req", W'(dm_req), 0);
        check("rst_err", W'(err), 0);
        check("rst_load_valid", W'(load_valid), 0);
        check("rst_dm_we", W'(dm_we), 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_load_data", load_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: load, ack on 2nd dm_req cycle
        expect_req(W'(8), 1'b0, '0);
        ld_q.push_back(W'(64'hDEAD_BEEF));
        l0 = lv_cnt;
        run_access(1'b1, 1'b0, W'(64'h40), '0, 2, W'(64'hDEAD_BEEF), sc, rc);
        check("t1_req_cycles", W'(rc), 2);
        check("t1_stall_cycles", W'(sc), 3);
        next_idle();
        check("t1_lv_count", W'(lv_cnt - l0), 1);
        check("t1_lv_pulse_low", W'(load_valid), 0);
        check("t1_load_data_held", load_data, W'(64'hDEAD_BEEF));
        check("t1_err", W'(err), 0);

        // 2: store, ack on 1st cycle (minimum access)
        expect_req(W'(3), 1'b1, W'(64'h1234));
        l0 = lv_cnt;
        run_access(1'b0, 1'b1, W'(64'h18), W'(64'h1234), 1, '0, sc, rc);
        check("t2_req_cycles", W'(rc), 1);
        check("t2_stall_cycles", W'(sc), 2);
        next_idle();
        check("t2_no_load_valid", W'(lv_cnt - l0), 0);
        check("t2_err", W'(err), 0);

        // 3: timeout, then late ack and new request are ignored
        expect_req(W'(16), 1'b0, '0);
        l0 = lv_cnt;
        run_access(1'b1, 1'b0, W'(64'h80), '0, 0, '0, sc, rc);
        check("t3_req_cycles", W'(rc), 15);
        check("t3_stall_cycles", W'(sc), 16);
        check("t3_err", W'(err), 1);
        check("t3_stall_in_err", W'(stall), 0);
        b0 = bursts;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = W'(64'h5555);
        @(negedge clk);
        check("t3_late_ack_no_req", W'(dm_req), 0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t3_err_sticky", W'(err), 1);
        check("t3_no_retrigger", W'(bursts - b0), 0);
        check("t3_no_load_valid", W'(lv_cnt - l0), 0);
        apply_reset();
        check("t3_err_cleared", W'(err), 0);

        // 4: reset on the 2nd dm_req cycle
        expect_req(W'(4), 1'b0, '0);
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = W'(64'h20);
        @(negedge clk);
        check("t4_stall_comb", W'(stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_req_cycle1", W'(dm_req), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        check("t4_dm_req", W'(dm_req), 0);
        check("t4_stall", W'(stall), 0);
        check("t4_dm_addr", dm_addr, 0);
        check("t4_dm_we", W'(dm_we), 0);
        check("t4_load_data", load_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 5: back-to-back load then store; DONE separates them
        expect_req(W'(64'h20), 1'b0, '0);
        ld_q.push_back(W'(64'h0123_4567_89AB_CDEF));
        expect_req(W'(64'h41), 1'b1, W'(64'hCAFE_F00D));
        b0 = bursts;
        l0 = lv_cnt;
        run_access(1'b1, 1'b0, W'(64'h100), '0, 1, W'(64'h0123_4567_89AB_CDEF), sc, rc);
        check("t5_ld_req_cycles", W'(rc), 1);
        check("t5_ld_stall_cycles", W'(sc), 2);
        run_access(1'b0, 1'b1, W'(64'h208), W'(64'hCAFE_F00D), 3, '0, sc, rc);
        check("t5_st_req_cycles", W'(rc), 3);
        check("t5_st_stall_cycles", W'(sc), 4);
        next_idle();
        check("t5_bursts", W'(bursts - b0), 2);
        check("t5_lv_count", W'(lv_cnt - l0), 1);
        check("t5_err", W'(err), 0);

        // Simultaneous read+write: write issued, err after completion
        expect_req(W'(6), 1'b1, W'(64'h55));
        l0 = lv_cnt;
        run_access(1'b1, 1'b1, W'(64'h30), W'(64'h55), 2, W'(64'hFFFF), sc, rc);
        check("dual_req_cycles", W'(rc), 2);
        check("dual_err", W'(err), 1);
        next_idle();
        check("dual_no_load_valid", W'(lv_cnt - l0), 0);
        apply_reset();

        // Stray ack in IDLE sets err on the following cycle
        @(posedge clk); #1;
        dm_ack = 1'b1;
        @(negedge clk);
        check("stray_ack_err_before", W'(err), 0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_err", W'(err), 1);
        check("stray_ack_no_req", W'(dm_req), 0);
        apply_reset();

        // 6: misaligned load
        b0 = bursts;
`ifdef MEM_ALIGN_CHECK_EN
        run_access(1'b1, 1'b0, W'(64'h43), '0, 2, W'(64'h77), sc, rc);
        check("t6_no_req", W'(rc), 0);
        check("t6_no_stall", W'(sc), 0);
        check("t6_err", W'(err), 1);
        next_idle();
        check("t6_bursts", W'(bursts - b0), 0);
        apply_reset();
`else
        expect_req(W'(8), 1'b0, '0);
        ld_q.push_back(W'(64'h77));
        run_access(1'b1, 1'b0, W'(64'h43), '0, 2, W'(64'h77), sc, rc);
        check("t6_req_cycles", W'(rc), 2);
        check("t6_stall_cycles", W'(sc), 3);
        next_idle();
        check("t6_err", W'(err), 0);
        check("t6_bursts", W'(bursts - b0), 1);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sb_req_drained", W'(req_q.size()), 0);
        check("sb_load_drained", W'(ld_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
